// File: rtl/debug_uart_pkg.sv
// Shared debug UART definitions: FSM encoding, frame/counter widths, divisor check.
// Used by both the transmit and receive paths.
package debug_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int BAUD_CNT_W = 16;
    localparam int BIT_CNT_W  = 3;

    function automatic bit divisor_ok(input int d);
        return (d >= 2) && (d <= 65535);
    endfunction

endpackage

// File: rtl/debug_uart_tx_if.sv
// Byte handshake and line/status signals of the debug UART transmitter.
interface debug_uart_tx_if;
    import debug_uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_serial;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_serial, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_serial, tx_busy, tx_done
    );
endinterface

// File: rtl/debug_uart_baud_tick.sv
// Bit-period counter: counts 0..DIVISOR-1 while running, tick_o in the wrap cycle.
// Held at zero when idle; restart_i forces it back to zero.
module debug_uart_baud_tick
    import debug_uart_pkg::*;
#(
    parameter int DIVISOR = 347
) (
    input  logic clk_in,
    input  logic reset,
    input  logic restart_i,
    input  logic run_i,
    output logic tick_o
);

    logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
    logic                  wrap;

    assign wrap   = (cnt_q == BAUD_CNT_W'(DIVISOR - 1));
    assign tick_o = run_i && wrap;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || !run_i || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: one byte per handshake, 8 data bits LSB first, 1 or 2 stop bits.
// Define DEBUG_UART_PARITY_EN to insert a parity bit after bit 7.
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 40000000,
    parameter int BAUDRATE   = 115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk_in,
    input  logic           reset,
    debug_uart_tx_if.slave tx_if
);

    localparam int DIVISOR = CLOCK_FREQ / BAUDRATE;

    if (!divisor_ok(DIVISOR)) begin : g_bad_divisor
        $error("debug_uart_tx: DIVISOR %0d outside 2..65535", DIVISOR);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("debug_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("debug_uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_e          state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 serial_q, serial_d;
    logic                 restart, tick, done;

`ifdef DEBUG_UART_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic parity_q, parity_d;

    assign parity_d = (state_q == ST_IDLE) ? ((^tx_if.tx_data) ^ ODD) : parity_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

    debug_uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud (
        .clk_in    (clk_in),
        .reset     (reset),
        .restart_i (restart),
        .run_i     (state_q != ST_IDLE),
        .tick_o    (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        serial_d  = serial_q;
        restart   = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                if (tx_if.tx_valid) begin
                    state_d   = ST_START;
                    shreg_d   = tx_if.tx_data;
                    serial_d  = 1'b0;
                    bit_cnt_d = '0;
                    restart   = 1'b1;
                end
            end
            ST_START: if (tick) begin
                state_d  = ST_DATA;
                serial_d = shreg_q[0];
                shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
            end
            ST_DATA: if (tick) begin
                if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                    bit_cnt_d = '0;
`ifdef DEBUG_UART_PARITY_EN
                    state_d  = ST_PARITY;
                    serial_d = parity_q;
`else
                    state_d  = ST_STOP;
                    serial_d = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    serial_d  = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                end
            end
`ifdef DEBUG_UART_PARITY_EN
            ST_PARITY: if (tick) begin
                state_d  = ST_STOP;
                serial_d = 1'b1;
            end
`endif
            ST_STOP: if (tick) begin
                if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                    state_d  = ST_IDLE;
                    serial_d = 1'b1;
                    done     = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            serial_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            serial_q  <= serial_d;
        end
    end

    assign tx_if.tx_ready  = (state_q == ST_IDLE);
    assign tx_if.tx_busy   = (state_q != ST_IDLE);
    assign tx_if.tx_serial = serial_q;
    assign tx_if.tx_done   = done;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Scoreboard bench for debug_uart_tx: three instances (default, odd parity, slow 2-stop).
// Expected frames are queued at acceptance and checked cycle by cycle on the line.
module tb_debug_uart_tx;

    localparam int DIV  = 40000000 / 115200;
    localparam int DIVS = 8 / 2;
`ifdef DEBUG_UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          div;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic       clk_in  = 1'b0;
    logic       reset   = 1'b1;
    int         dsel    = 0;
    logic       valid_r = 1'b0;
    logic [7:0] data_r  = 8'h00;

    always #5 clk_in = ~clk_in;

    debug_uart_tx_if if0 ();
    debug_uart_tx_if if1 ();
    debug_uart_tx_if if2 ();

    assign if0.tx_valid = valid_r && (dsel == 0);
    assign if1.tx_valid = valid_r && (dsel == 1);
    assign if2.tx_valid = valid_r && (dsel == 2);
    assign if0.tx_data  = data_r;
    assign if1.tx_data  = data_r;
    assign if2.tx_data  = data_r;

    debug_uart_tx #(.CLOCK_FREQ(40000000), .BAUDRATE(115200), .STOP_BITS(1), .PARITY_ODD(0))
        dut0 (.clk_in(clk_in), .reset(reset), .tx_if(if0));
    debug_uart_tx #(.CLOCK_FREQ(40000000), .BAUDRATE(115200), .STOP_BITS(1), .PARITY_ODD(1))
        dut1 (.clk_in(clk_in), .reset(reset), .tx_if(if1));
    debug_uart_tx #(.CLOCK_FREQ(8), .BAUDRATE(2), .STOP_BITS(2), .PARITY_ODD(0))
        dut2 (.clk_in(clk_in), .reset(reset), .tx_if(if2));

    logic m_ser, m_busy, m_done, m_rdy;
    always_comb begin
        m_ser  = if0.tx_serial;
        m_busy = if0.tx_busy;
        m_done = if0.tx_done;
        m_rdy  = if0.tx_ready;
        case (dsel)
            1: begin
                m_ser = if1.tx_serial; m_busy = if1.tx_busy;
                m_done = if1.tx_done;  m_rdy = if1.tx_ready;
            end
            2: begin
                m_ser = if2.tx_serial; m_busy = if2.tx_busy;
                m_done = if2.tx_done;  m_rdy = if2.tx_ready;
            end
            default: ;
        endcase
    end

    function automatic exp_t exp_for(input logic [7:0] d, input int sel);
        exp_t e;
        int   n;
        int   stops;
        logic odd;
        odd    = (sel == 1);
        stops  = (sel == 2) ? 2 : 1;
        e.bits = '0;
        for (int i = 0; i < 8; i++) e.bits[1 + i] = d[i];
        n = 9;
        if (PB == 1) begin
            e.bits[n] = (^d) ^ odd;
            n++;
        end
        for (int s = 0; s < stops; s++) e.bits[n + s] = 1'b1;
        e.nbits = n + stops;
        e.div   = (sel == 2) ? DIVS : DIV;
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (m_rdy !== 1'b1 && n < 5000) begin
            @(negedge clk_in);
            n++;
        end
        if (m_rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: tx_ready=%b after %0d cycles, required 1", m_rdy, n);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
        wait_ready();
        valid_r = 1'b1;
        data_r  = d;
        @(posedge clk_in);
        sb.push_back(exp_for(d, dsel));
        #1;
        if (!hold) valid_r = 1'b0;
    endtask

    task automatic check_frame(input string name);
        exp_t e;
        int   total;
        int   errs = 0, first_bad = -1, busy_err = 0, done_err = 0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty, required one expected frame", name);
            return;
        end
        e     = sb.pop_front();
        total = e.nbits * e.div;
        for (int c = 0; c < total; c++) begin
            @(negedge clk_in);
            if (m_ser !== e.bits[c / e.div]) begin
                errs++;
                if (first_bad < 0) first_bad = c;
            end
            if (m_busy !== 1'b1) busy_err++;
            if (m_done !== (c == total - 1)) done_err++;
        end
        vectors++;
        if (errs !== 0) begin
            miscompares++;
            $display("FAIL %s_bits: %0d wrong line cycles (first at %0d), required frame %b (lsb first, %0d bits)",
                     name, errs, first_bad, e.bits, e.nbits);
        end
        vectors++;
        if (busy_err !== 0) begin
            miscompares++;
            $display("FAIL %s_busy: tx_busy low in %0d frame cycles, required 0", name, busy_err);
        end
        vectors++;
        if (done_err !== 0) begin
            miscompares++;
            $display("FAIL %s_done: tx_done wrong in %0d cycles, required single pulse at cycle %0d",
                     name, done_err, total - 1);
        end
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clk_in);
        vectors++;
        if (m_rdy !== 1'b1 || m_ser !== 1'b1 || m_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: ready=%b serial=%b busy=%b, required 1 1 0", name, m_rdy, m_ser, m_busy);
        end
    endtask

    task automatic test_reset();
        dsel = 0;
        repeat (3) @(negedge clk_in);
        vectors++;
        if (m_ser !== 1'b1) begin miscompares++; $display("FAIL reset_serial: %b, required 1", m_ser); end
        vectors++;
        if (m_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: %b, required 0", m_busy); end
        vectors++;
        if (m_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: %b, required 0", m_done); end
        vectors++;
        if (m_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_ready: %b, required 1", m_rdy); end
        reset = 1'b0;
        check_idle_after("post_reset");
    endtask

    task automatic test_basic();
        dsel = 0;
        send(8'h55, 1'b0);
        check_frame("basic_55");
        check_idle_after("basic_55");
        send(8'hE1, 1'b0);
        check_frame("basic_e1");
        check_idle_after("basic_e1");
    endtask

    task automatic test_parity();
        dsel = 0;
        send(8'hA5, 1'b0);
        check_frame("parity_even_a5");
        check_idle_after("parity_even_a5");
        dsel = 1;
        send(8'hA5, 1'b0);
        check_frame("parity_odd_a5");
        check_idle_after("parity_odd_a5");
        dsel = 0;
    endtask

    task automatic test_back_to_back();
        dsel = 0;
        wait_ready();
        valid_r = 1'b1;
        data_r  = 8'h00;
        @(posedge clk_in);
        sb.push_back(exp_for(8'h00, dsel));
        #1 data_r = 8'hFF;
        check_frame("b2b_first");
        @(negedge clk_in);
        vectors++;
        if (m_ser !== 1'b1 || m_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_gap: serial=%b ready=%b, required 1 1", m_ser, m_rdy);
        end
        @(posedge clk_in);
        sb.push_back(exp_for(8'hFF, dsel));
        #1 valid_r = 1'b0;
        check_frame("b2b_second");
        check_idle_after("b2b_second");
    endtask

    task automatic test_ignore_midframe();
        int extra = 0;
        dsel = 0;
        send(8'h96, 1'b0);
        fork
            check_frame("ignore_frame");
            begin
                repeat (1200) @(posedge clk_in);
                #1;
                valid_r = 1'b1;
                data_r  = 8'h3C;
                @(posedge clk_in);
                #1 valid_r = 1'b0;
            end
        join
        repeat (1000) begin
            @(negedge clk_in);
            if (m_done !== 1'b0 || m_busy !== 1'b0 || m_ser !== 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL ignore_no_second_frame: %0d active cycles after frame, required 0", extra);
        end
    endtask

    task automatic test_reset_midframe();
        int done_seen = 0;
        dsel = 0;
        send(8'hC3, 1'b0);
        repeat (5 * DIV + DIV / 2) @(posedge clk_in);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (m_ser !== 1'b1 || m_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async: serial=%b busy=%b, required 1 0", m_ser, m_busy);
        end
        repeat (4) begin
            @(negedge clk_in);
            if (m_done !== 1'b0) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_done: tx_done seen %0d cycles, required 0", done_seen);
        end
        reset = 1'b0;
        void'(sb.pop_front());
        check_idle_after("reset_mid_release");
        send(8'h5A, 1'b0);
        check_frame("after_reset_5a");
        check_idle_after("after_reset_5a");
    endtask

    task automatic test_slow_two_stop();
        dsel = 2;
        send(8'h80, 1'b0);
        check_frame("slow_80");
        check_idle_after("slow_80");
        send(8'h01, 1'b0);
        check_frame("slow_01");
        check_idle_after("slow_01");
        dsel = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_slow_two_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
